complex_adder: RTL and testbench

- Registered adder for signed fixed-point complex numbers, used in the FFT datapath of the audio visualizer (butterfly and accumulate stages).
- Adds two complex operands, each packed as {real, imag}, and produces a packed complex sum one clock after the operands are presented.
- Reports per-component overflow; saturation is an optional compile-time feature.

---
 rtl/complex_pkg.sv | 32 +++
 rtl/signed_add_ovf.sv | 46 ++++
 rtl/complex_adder.sv | 77 +++++++
 tb/tb_complex_adder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/complex_pkg.sv
// complex_pkg: shared types and helpers for the signed fixed-point complex datapath.
// A complex value is packed {re, im}: real in the MSB half, imag in the LSB half.
// The optional saturating build is selected by COMPLEX_ADDER_SATURATE_EN (see signed_add_ovf).
package complex_pkg;

    // Width of each real/imag component.
    localparam int CPLX_DW = 16;

    // Packed complex word; field order matches the {real, imag} bus layout.
    typedef struct packed {
        logic signed [CPLX_DW-1:0] re;
        logic signed [CPLX_DW-1:0] im;
    } complex_t;

    // Saturation limits for one component.
    localparam logic signed [CPLX_DW-1:0] CPLX_MAX = {1'b0, {(CPLX_DW-1){1'b1}}};
    localparam logic signed [CPLX_DW-1:0] CPLX_MIN = {1'b1, {(CPLX_DW-1){1'b0}}};

    // Split a packed bus word into its components.
    function automatic complex_t cplx_unpack(input logic [2*CPLX_DW-1:0] w);
        complex_t c;
        c.re = w[2*CPLX_DW-1:CPLX_DW];
        c.im = w[CPLX_DW-1:0];
        return c;
    endfunction

    // Join components back into a packed bus word.
    function automatic logic [2*CPLX_DW-1:0] cplx_pack(input complex_t c);
        return {c.re, c.im};
    endfunction

endpackage

// File: rtl/signed_add_ovf.sv
// signed_add_ovf: combinational DW-bit two's-complement add with overflow detect.
// Overflow: both operands share a sign and the DW-bit result sign differs.
// Default build wraps; with COMPLEX_ADDER_SATURATE_EN defined the result clamps
// to the positive or negative limit on overflow. ovf is reported in both builds.
module signed_add_ovf #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    output logic [DW-1:0] sum,
    output logic          ovf
);

    localparam logic [DW-1:0] POS_LIMIT = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_LIMIT = {1'b1, {(DW-1){1'b0}}};

    logic [DW:0]   full_sum;
    logic [DW-1:0] wrap_sum;

    // Sign-extended full-precision sum, then overflow from operand/result signs.
    always_comb begin
        full_sum = {x[DW-1], x} + {y[DW-1], y};
        wrap_sum = full_sum[DW-1:0];
        ovf      = (x[DW-1] == y[DW-1]) && (wrap_sum[DW-1] != x[DW-1]);
    end

`ifdef COMPLEX_ADDER_SATURATE_EN
    // Clamp toward the operands' common sign when the result overflowed.
    always_comb begin
        sum = wrap_sum;
        if (ovf) begin
            sum = x[DW-1] ? NEG_LIMIT : POS_LIMIT;
        end
    end
`else
    // Two's-complement wrap: keep the low DW bits.
    always_comb begin
        sum = wrap_sum;
    end

    // Limits are only used by the saturating build.
    logic unused_limits;
    assign unused_limits = ^{POS_LIMIT, NEG_LIMIT};
`endif

endmodule

// File: rtl/complex_adder.sv
// complex_adder: registered adder for packed signed complex operands {re, im}.
// One result per cycle, latency one clock, no backpressure.
// Handshake: in_valid=1 at a rising edge captures a/b; after that edge
// out_valid=1 and c/ovf_real/ovf_imag carry the sum. in_valid=0 at an edge
// gives out_valid=0 and leaves c and the flags unchanged. rst (synchronous,
// active-high) wins over in_valid and clears all outputs.
// Build option: COMPLEX_ADDER_SATURATE_EN selects saturating lanes.
module complex_adder
    import complex_pkg::*;
#(
    parameter int DW = CPLX_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [2*DW-1:0] a,
    input  logic [2*DW-1:0] b,
    output logic [2*DW-1:0] c,
    output logic            out_valid,
    output logic            ovf_real,
    output logic            ovf_imag
);

    complex_t a_c;
    complex_t b_c;
    complex_t sum_c;
    logic     ovf_re_d;
    logic     ovf_im_d;

    complex_t c_q;
    logic     valid_q;
    logic     ovf_re_q;
    logic     ovf_im_q;

    // Unpack the bus words into components.
    always_comb begin
        a_c = cplx_unpack(a);
        b_c = cplx_unpack(b);
    end

    signed_add_ovf #(.DW(DW)) u_lane_re (
        .x   (a_c.re),
        .y   (b_c.re),
        .sum (sum_c.re),
        .ovf (ovf_re_d)
    );

    signed_add_ovf #(.DW(DW)) u_lane_im (
        .x   (a_c.im),
        .y   (b_c.im),
        .sum (sum_c.im),
        .ovf (ovf_im_d)
    );

    // Output register: capture on in_valid, hold otherwise, clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q      <= '0;
            valid_q  <= 1'b0;
            ovf_re_q <= 1'b0;
            ovf_im_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                c_q      <= sum_c;
                ovf_re_q <= ovf_re_d;
                ovf_im_q <= ovf_im_d;
            end
        end
    end

    assign c         = cplx_pack(c_q);
    assign out_valid = valid_q;
    assign ovf_real  = ovf_re_q;
    assign ovf_imag  = ovf_im_q;

endmodule

// File: tb/tb_complex_adder.sv
// tb_complex_adder: scoreboard bench for complex_adder (wrap or saturating build).
module tb_complex_adder;

    localparam int DW = 16;
    localparam int W  = 2 * DW;
    localparam int EW = W + 2;   // scoreboard entry {c, ovf_real, ovf_imag}

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         out_valid;
    logic         ovf_real;
    logic         ovf_imag;

    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  hold_c;
    logic [1:0]    hold_f;
    int            n_checks;
    int            n_fail;

    complex_adder #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .ovf_real  (ovf_real),
        .ovf_imag  (ovf_imag)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare and count.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference for one lane using integer range checks; returns {ovf, result}.
    function automatic logic [DW:0] lane_model(input logic [DW-1:0] x, input logic [DW-1:0] y);
        int s;
        int maxv;
        int minv;
        logic [31:0] sv;
        logic ov;
        logic [DW-1:0] r;
        maxv = (1 << (DW - 1)) - 1;
        minv = -(1 << (DW - 1));
        s = int'($signed(x)) + int'($signed(y));
        ov = (s > maxv) || (s < minv);
        sv = s;
        r = sv[DW-1:0];
`ifdef COMPLEX_ADDER_SATURATE_EN
        if (s > maxv) r = maxv[DW-1:0];
        if (s < minv) r = minv[DW-1:0];
`endif
        return {ov, r};
    endfunction

    function automatic logic [EW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [DW:0] re;
        logic [DW:0] im;
        re = lane_model(av[W-1:DW], bv[W-1:DW]);
        im = lane_model(av[DW-1:0], bv[DW-1:0]);
        return {re[DW-1:0], im[DW-1:0], re[DW], im[DW]};
    endfunction

    function automatic logic [W-1:0] pk(input int re, input int im);
        logic [31:0] r32;
        logic [31:0] i32;
        r32 = re;
        i32 = im;
        return {r32[DW-1:0], i32[DW-1:0]};
    endfunction

    // Drive one cycle, then check what the DUT shows after the edge.
    task automatic step(input logic r, input logic v, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [EW-1:0] e;
        rst = r;
        in_valid = v;
        a = av;
        b = bv;
        if (v && !r) exp_q.push_back(model(av, bv));
        @(posedge clk);
        #1;
        if (r) begin
            check("rst_c", c, 0);
            check("rst_valid", out_valid, 0);
            check("rst_ovf", {ovf_real, ovf_imag}, 0);
            hold_c = '0;
            hold_f = '0;
        end else begin
            check("out_valid", out_valid, v);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum_c", c, e[EW-1:2]);
                    check("ovf", {ovf_real, ovf_imag}, e[1:0]);
                    hold_c = e[EW-1:2];
                    hold_f = e[1:0];
                end
            end else begin
                check("hold_c", c, hold_c);
                check("hold_ovf", {ovf_real, ovf_imag}, hold_f);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        hold_c = '0;
        hold_f = '0;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);

        // Test-plan vectors
        step(1'b0, 1'b1, pk(16383, 16383), pk(16383, 16383));
        check("plan_fullscale", c, 32'h7FFE_7FFE);
        step(1'b0, 1'b1, pk(16383, -16384), pk(16383, -16384));
        check("plan_exact_min", c, 32'h7FFE_8000);
        step(1'b0, 1'b1, pk(16383, 16383), pk(-16384, -16384));
        check("plan_minus_one", c, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, pk(0, 16383), pk(0, 16383));
        step(1'b0, 1'b1, pk(-16384, 0), pk(-16384, 0));
        step(1'b0, 1'b1, pk(0, -16384), pk(0, -16384));
        check("plan_imag_min", c, 32'h0000_8000);
        step(1'b0, 1'b1, pk(32767, -32768), pk(1, -1));
`ifdef COMPLEX_ADDER_SATURATE_EN
        check("plan_ovf_sat", c, 32'h7FFF_8000);
`else
        check("plan_ovf_wrap", c, 32'h8000_7FFF);
`endif
        check("plan_ovf_flags", {ovf_real, ovf_imag}, 2'b11);

        // Boundaries, one lane overflowing at a time
        step(1'b0, 1'b1, 32'h7FFF_0001, 32'h0001_0001);
        step(1'b0, 1'b1, 32'h0005_8000, 32'h0003_FFFF);
        step(1'b0, 1'b1, 32'hC000_C000, 32'hC000_C000);
        check("exact_fit_flags", {ovf_real, ovf_imag}, 2'b00);
        step(1'b0, 1'b1, 32'h7FFF_8000, 32'h8000_7FFF);

        // Idle: out_valid drops, outputs hold
        step(1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111);
        step(1'b0, 1'b0, '0, '0);

        // Back-to-back burst of four
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, W'($urandom), W'($urandom));
        end

        // Reset together with in_valid, and with a result in flight
        step(1'b0, 1'b1, 32'h7FFF_7FFF, 32'h7FFF_7FFF);
        step(1'b1, 1'b1, 32'h7FFF_7FFF, 32'h7FFF_7FFF);
        step(1'b0, 1'b0, '0, '0);

        // Random traffic with near-limit values mixed in
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) ra[W-1:DW] = 16'h7FF0 + 16'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rb[DW-1:0] = 16'h8000 + 16'($urandom_range(0, 15));
            step(1'b0, 1'($urandom_range(0, 3) != 0), ra, rb);
        end
        step(1'b0, 1'b0, '0, '0);

        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
